// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the fetch unit, its instruction buffer and the
// testbench.
//   fetch_state_t : fetch FSM states (IDLE, WAIT, DROP)
//   fetch_entry_t : one instruction-buffer entry {pc, instr, fault}
//   NOP_INSTR     : word delivered for a misaligned fetch
//   DEFAULT_DEPTH : default instruction-buffer depth
//   MAX_ADDR_W    : width of the pc field in fetch_entry_t; ADDR_W of the
//                   fetch unit must not exceed it
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned DEFAULT_DEPTH = 2;
    localparam int unsigned MAX_ADDR_W    = 32;
    localparam logic [31:0] NOP_INSTR     = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // free to issue a fetch
        WAIT = 2'd1,  // one read outstanding, response will be kept
        DROP = 2'd2   // one read outstanding, response will be discarded
    } fetch_state_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [31:0]           instr;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bus bundle of the fetch unit: the instruction-memory read port and the
// IF/ID output handshake.
//   imem_req_o/imem_addr_o       : one-cycle read request and its address
//   imem_rvalid_i/imem_rdata_i   : read response (at least one cycle later)
//   instr_valid_o/instr_ready_i  : IF/ID handshake
//   instr_o/instr_pc_o/instr_fault_o : head entry payload
//
// Handshake: an IF/ID transfer happens on a rising edge where instr_valid_o
// and instr_ready_i are both high. The payload is stable while valid is high
// and not yet accepted; valid never depends combinationally on ready.
//
// master modport: the fetch unit. slave modport: memory + decode side.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_rvalid_i;
    logic [31:0]       imem_rdata_i;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_fault_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, instr_pc_o, instr_fault_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, instr_pc_o, instr_fault_o,
        output instr_ready_i
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo
// Synchronous instruction buffer. Head data comes straight from the storage
// registers so the IF/ID payload has no logic in front of it.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clear_i       : drop all entries (pipeline redirect); wins over push/pop
//   push_i/push_data_i : write one entry; caller guarantees not full
//   pop_i         : remove head; caller guarantees not empty
//   head_data_o   : head entry
//   count_o       : number of stored entries
//   valid_o       : head entry present
// ---------------------------------------------------------------------------
module if_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Storage is reset so the payload outputs read zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of two: wraps
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data_o = mem[rd_ptr];
    assign count_o     = count;
    assign valid_o     = (count != '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch side of the program counter: accepts pc_i, issues one outstanding
// read to instruction memory, buffers {pc, word, fault} entries for IF/ID,
// turns misaligned PCs into faulting NOP entries and discards responses that
// belong to a redirected path.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   pc_i           : current PC register value
//   pc_advance_o   : pc_i accepted; PC register loads its next value
//   flush_i        : redirect; PC register is reloaded this cycle
//   bus            : imem read port and IF/ID handshake (master side)
//   dbg_state_o    : current fetch FSM state
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     pc_i,
    output logic                  pc_advance_o,
    input  logic                  flush_i,
    instr_fetch_unit_if.master    bus,
    output fetch_state_t          dbg_state_o
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = $bits(fetch_entry_t);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pend_pc;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_valid;
    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    logic              issue_ok;
    logic              pc_aligned;
    logic              mem_req;
    logic              mis_push;
    logic              mem_push;

    // The registered count reserves a slot for the outstanding read, so a
    // response never finds the buffer full. A same-cycle pop is not credited.
    assign issue_ok   = (state == IDLE) && !flush_i && !rst_i &&
                        (fifo_count < CNT_W'(DEPTH));
    assign pc_aligned = (pc_i[1:0] == 2'b00);
    assign mem_req    = issue_ok && pc_aligned;
    assign mis_push   = issue_ok && !pc_aligned;
    // A response arriving together with a flush belongs to the old path.
    assign mem_push   = (state == WAIT) && bus.imem_rvalid_i && !flush_i;

    assign fifo_push  = mem_push || mis_push;
    assign fifo_pop   = fifo_valid && bus.instr_ready_i && !flush_i;

    always_comb begin
        push_entry = '0;
        if (mem_push) begin
            push_entry.pc    = MAX_ADDR_W'(pend_pc);
            push_entry.instr = bus.imem_rdata_i;
            push_entry.fault = 1'b0;
        end else begin
            push_entry.pc    = MAX_ADDR_W'(pc_i);
            push_entry.instr = NOP_INSTR;
            push_entry.fault = 1'b1;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (flush_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_data_o (head_entry),
        .count_o     (fifo_count),
        .valid_o     (fifo_valid)
    );

    // Fetch FSM. WAIT vs DROP records whether the outstanding response is
    // still wanted; either way the next rvalid closes the transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        pend_pc <= pc_i;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        state <= IDLE;
                    end else if (flush_i) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pc_advance_o      = issue_ok;
    assign bus.imem_req_o    = mem_req;
    assign bus.imem_addr_o   = mem_req ? pc_i : '0;

    // Outputs are forced low during reset so stale buffer contents never
    // show in the cycle reset is first applied.
    assign bus.instr_valid_o = fifo_valid && !rst_i;
    assign bus.instr_o       = rst_i ? '0 : head_entry.instr;
    assign bus.instr_pc_o    = rst_i ? '0 : head_entry.pc[ADDR_W-1:0];
    assign bus.instr_fault_o = head_entry.fault && !rst_i;

    assign dbg_state_o       = state;

endmodule
